// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick divider. Each channel is a count-up divider
// with a shadowed divide value that takes effect only at wrap, sync or while disabled.
module prog_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 10,
    parameter int CH_W        = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  div_act [NUM_CH];
    logic [CNT_W-1:0]  div_shd [NUM_CH];
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] wr_hit;

    // Out-of-range channel indices match no channel, so those writes are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= DIV_RST;
                div_shd[i] <= DIV_RST;
            end
            mode_q  <= '0;
            clkout  <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync || !en[i]) begin
                    cnt[i]    <= '0;
                    tick[i]   <= 1'b0;
                    clkout[i] <= 1'b0;
                    mode_q[i] <= mode[i];
                    if (pending[i]) begin
                        div_act[i] <= div_shd[i];
                    end
                    pending[i] <= 1'b0;
                end else if (cnt[i] == div_act[i]) begin
                    cnt[i]    <= '0;
                    tick[i]   <= 1'b1;
                    clkout[i] <= mode_q[i] ? 1'b1 : ~clkout[i];
                    mode_q[i] <= mode[i];
                    if (pending[i]) begin
                        div_act[i] <= div_shd[i];
                    end
                    pending[i] <= 1'b0;
                end else begin
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                    tick[i] <= 1'b0;
                    if (mode_q[i]) begin
                        clkout[i] <= 1'b0;
                    end
                end
                // A write landing on a wrap/sync edge stays pending; the apply above used the old shadow.
                if (wr_hit[i]) begin
                    div_shd[i] <= wr_data;
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: expected tick cycles go into a queue when stimulus
// is applied and are popped as the watched channel ticks.
module tb_prog_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 26;
    localparam int CH_W   = 3;

    logic              clkin = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] mode;
    logic              sync;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_data;
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int watch = 0;
    bit sb_on = 1'b0;
    int exp_q[$];

    prog_clock_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(10), .CH_W(CH_W)
    ) dut (
        .clkin(clkin), .rst(rst), .en(en), .mode(mode), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clkout(clkout), .tick(tick), .pending(pending)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor samples exactly on the falling edge; stimulus acts 1 ns later.
    always @(negedge clkin) begin
        if (sb_on && tick[watch] === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexp", 32'(tick[watch]), 32'd0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("tick_cyc", cyc, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clkin);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_data = CNT_W'(d);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        step(1);
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
    endtask

    task automatic sb_close(input string tag);
        sb_on = 1'b0;
        chk(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, s, r, y;
        step(1);
        do_reset();
        step(2);

        // Default divide 10 in toggle mode on ch0
        k = cyc;
        en = 4'b0001;
        watch = 0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(k + 11 * i);
        sb_on = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            step(1);
            chk("t1_clkout", 32'(clkout[0]), (j >= 11 && ((j - 11) / 11) % 2 == 0) ? 32'd1 : 32'd0);
        end
        sb_close("t1_sb_left");

        // Mid-period write on ch1: old period finishes, then D=3
        do_reset();
        k = cyc;
        en = 4'b0010;
        watch = 1;
        exp_q.push_back(k + 11);
        exp_q.push_back(k + 15);
        exp_q.push_back(k + 19);
        exp_q.push_back(k + 23);
        sb_on = 1'b1;
        step(5);
        wr(1, 3);
        chk("t2_pend_set", 32'(pending[1]), 32'd1);
        step(4);
        chk("t2_pend_hold", 32'(pending[1]), 32'd1);
        step(1);
        chk("t2_pend_clr", 32'(pending[1]), 32'd0);
        step(13);
        sb_close("t2_sb_left");

        // Pulse mode ch2: D=0 holds high, then D=2
        do_reset();
        mode = 4'b0100;
        wr(2, 0);
        step(1);
        chk("t3_pend_applied", 32'(pending[2]), 32'd0);
        en = 4'b0100;
        for (int j = 0; j < 6; j++) begin
            step(1);
            chk("t3_d0_tick", 32'(tick[2]), 32'd1);
            chk("t3_d0_clk", 32'(clkout[2]), 32'd1);
        end
        m = cyc;
        wr(2, 2);
        watch = 2;
        for (int i = 0; i < 4; i++) exp_q.push_back(m + 2 + 3 * i);
        sb_on = 1'b1;
        for (int j = 2; j <= 12; j++) begin
            step(1);
            chk("t3_d2_clk", 32'(clkout[2]), ((cyc - (m + 2)) % 3 == 0) ? 32'd1 : 32'd0);
        end
        sb_close("t3_sb_left");

        // Sync aligns ch1/ch3 (both D=4); out-of-range write ignored
        do_reset();
        wr(1, 4);
        wr(3, 4);
        step(1);
        chk("t4_pend_applied", 32'(pending), 32'd0);
        en = 4'b0010;
        step(2);
        en = 4'b1010;
        step(3);
        wr(5, 1);
        chk("t4_badwr", 32'(pending), 32'd0);
        s = cyc;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("t4_sync_tick", 32'(tick), 32'd0);
        chk("t4_sync_clk", 32'(clkout), 32'd0);
        watch = 1;
        exp_q.push_back(s + 6);
        exp_q.push_back(s + 11);
        exp_q.push_back(s + 16);
        sb_on = 1'b1;
        for (int j = 2; j <= 17; j++) begin
            step(1);
            chk("t4_tick3", 32'(tick[3]),
                (cyc >= s + 6 && (cyc - (s + 6)) % 5 == 0) ? 32'd1 : 32'd0);
        end
        sb_close("t4_sb_left");

        // Disable mid-period with a pending write
        do_reset();
        k = cyc;
        en = 4'b0001;
        step(11);
        chk("t5_first_tick", 32'(tick[0]), 32'd1);
        chk("t5_clk_high", 32'(clkout[0]), 32'd1);
        step(1);
        wr(0, 2);
        chk("t5_pend", 32'(pending[0]), 32'd1);
        chk("t5_clk_still", 32'(clkout[0]), 32'd1);
        en = 4'b0000;
        step(1);
        chk("t5_dis_clk", 32'(clkout[0]), 32'd0);
        chk("t5_dis_tick", 32'(tick[0]), 32'd0);
        chk("t5_dis_pend", 32'(pending[0]), 32'd0);
        step(2);
        r = cyc;
        en = 4'b0001;
        watch = 0;
        exp_q.push_back(r + 3);
        exp_q.push_back(r + 6);
        exp_q.push_back(r + 9);
        sb_on = 1'b1;
        step(3);
        chk("t5_reen_clk", 32'(clkout[0]), 32'd1);
        step(7);
        sb_close("t5_sb_left");

        // Reset mid-count discards pending values
        do_reset();
        en = 4'b0011;
        step(3);
        wr(0, 7);
        wr(1, 9);
        chk("t6_pend_both", 32'(pending), 32'd3);
        rst = 1'b1;
        step(1);
        chk("t6_rst_clk", 32'(clkout), 32'd0);
        chk("t6_rst_tick", 32'(tick), 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        rst = 1'b0;
        y = cyc;
        watch = 0;
        exp_q.push_back(y + 11);
        exp_q.push_back(y + 22);
        sb_on = 1'b1;
        step(11);
        chk("t6_ch1_default", 32'(tick[1]), 32'd1);
        step(12);
        sb_close("t6_sb_left");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Multi-channel, runtime-programmable clock/tick divider. Replaces fixed single-output dividers in the traffic-light and display paths. Each channel produces a 50%-duty divided clock or a one-cycle tick strobe from the single system clock. Divide values are programmed through a simple write port and applied glitch-free at period boundaries. A global sync input phase-aligns all channels.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 26, counter and divide-value width in bits
DEFAULT_DIV, 10, divide value loaded into every channel at reset (must fit CNT_W)
CH_W, 2, width of wr_ch; must be >= clog2(NUM_CH), minimum 1

Ports:
clkin  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel enable
mode  in  NUM_CH  per-channel mode: 0 = toggle (50% duty clock), 1 = pulse (one-cycle strobe)
sync  in  1  one-cycle request to restart all channels in phase
wr_en  in  1  divide-value write strobe
wr_ch  in  CH_W  channel index for the write
wr_data  in  CNT_W  new divide value D; output period is D+1 cycles (pulse) or 2(D+1) cycles (toggle)
clkout  out  NUM_CH  divided clock (toggle mode) or copy of tick (pulse mode)
tick  out  NUM_CH  one-cycle strobe at each count wrap
pending  out  NUM_CH  shadow divide value is waiting to be applied

Behaviour:
- Per-channel state: cnt[CNT_W], div_act, div_shd, pend, mode_q, clkout, tick. All state is registered; no combinational path from inputs to outputs.
- Reset (rst=1 at an edge): cnt=0, div_act=div_shd=DEFAULT_DIV, pend=0, mode_q=0, clkout=0, tick=0 for every channel. rst has priority over every other input.
- Enabled channel, per edge:
  - If cnt==div_act (wrap): cnt<=0 and tick<=1.
    - mode_q=0: clkout toggles.
    - mode_q=1: clkout<=1.
    - If pend=1: div_act<=div_shd and pend<=0.
    - mode_q<=mode.
  - Otherwise: cnt<=cnt+1, tick<=0. If mode_q=1, clkout<=0; if mode_q=0, clkout is held.
- Latency: en is first sampled high with cnt=0 at edge E0. The first wrap is at edge E_D, so tick is high during the cycle after E_D. Tick then repeats every D+1 cycles.
- D=0: tick is high continuously. Toggle mode gives clkin/2.
- Disabled channel (en=0): cnt<=0, tick<=0, clkout<=0, mode_q<=mode. If pend=1, div_shd is copied to div_act and pend clears on that edge.
- Write: wr_en=1 with wr_ch<NUM_CH sets div_shd[wr_ch]<=wr_data and pend<=1. Writes with wr_ch>=NUM_CH are ignored.
  - Multiple writes before a wrap: the last one wins.
  - Write on the same edge as a wrap: the wrap applies the old div_shd, and the new value becomes pending (pend stays 1).
- Counting arithmetic is unsigned modulo 2^CNT_W, but wrap occurs at div_act, so cnt never exceeds div_act.
- If div_act is reduced below the current cnt: impossible, because updates happen only at wrap or while disabled.
- sync=1 (not in reset), all channels: cnt<=0, clkout<=0, tick<=0. Pending values are applied and mode_q<=mode. Channels with en=1 count from 0 on the following edge, so all enabled channels with equal D tick on the same cycles. sync overrides wrap on the same edge. A write on the same edge as sync is captured as pending, not applied.
- Reset mid-operation: all channels return to the reset state on that edge. Programmed values are lost.
- Glitch-free guarantee: clkout changes only at wrap, sync, disable, or reset.

Test Plan:
- Reset, en=4'b0001, mode=0, DEFAULT_DIV=10 -> ch0 tick every 11 cycles; clkout period 22 cycles, high 11 / low 11; first tick in the cycle after edge E10.
- Write ch1 D=3 while ch1 enabled at D=10, mid-period (cnt=5) -> pending[1]=1 until the next wrap. Old period 11 completes. Subsequent ticks every 4 cycles, and pending[1] clears at that wrap.
- ch2 mode=1, D=0 -> tick[2] and clkout[2] both held at 1. Then D=2 -> clkout[2] equals tick[2], one cycle high, two low.
- Two channels, D=4 and D=4 at different phases, pulse sync -> both tick on identical cycles, 5 cycles apart. A write to wr_ch=5 (NUM_CH=4) changes nothing.
- Deassert en[0] mid-period -> clkout[0] and tick[0] are 0 on the next edge. A pending write is applied immediately; re-enabling starts the new period from cnt=0.
- Assert rst mid-count with pending writes -> all outputs 0. Divide values return to DEFAULT_DIV and pending=0 on the same edge.
